// File: rtl/demux_deser_if.sv
// Word-in / lane-register-out bus of the demultiplexing deserialiser.
// slave is the block side and master is the producer/consumer side.
interface demux_deser_if #(
    parameter int DATA_WIDTH = 4,
    parameter int NUM_CHAN   = 2,
    parameter int SEL_WIDTH  = 1
);
    logic [DATA_WIDTH-1:0]          inData;
    logic                           inValid;
    logic                           outReady;
    logic [SEL_WIDTH-1:0]           inSel;
    logic                           inMode;
    logic                           inAck;
    logic [NUM_CHAN*DATA_WIDTH-1:0] outData;
    logic                           outValid;
    logic [NUM_CHAN-1:0]            outChanMask;
    logic                           outError;

    modport slave (
        input  inData, inValid, inSel, inMode, inAck,
        output outReady, outData, outValid, outChanMask, outError
    );

    modport master (
        output inData, inValid, inSel, inMode, inAck,
        input  outReady, outData, outValid, outChanMask, outError
    );
endinterface

// File: rtl/demux_deser.sv
// Routes input words into held lane registers, either by address (inSel) or
// sequentially with a pointer that assembles NUM_CHAN words into an acked frame.
module demux_deser #(
    parameter int DATA_WIDTH = 4,
    parameter int NUM_CHAN   = 2,
    parameter int SEL_WIDTH  = 1
) (
    input  logic          inClk,
    input  logic          inReset,
    demux_deser_if.slave  bus
);
    logic [NUM_CHAN-1:0][DATA_WIDTH-1:0] r_data;
    logic                 r_apulse;
    logic [NUM_CHAN-1:0]  r_amask;
    logic                 r_err;
    logic                 r_pend;
    logic [SEL_WIDTH-1:0] r_ptr;
    logic                 r_mode_prev;

    logic                 w_ready;
    logic                 w_xfer;
    logic                 w_seq_xfer;
    logic                 w_addr_xfer;
    logic                 w_sel_ok;
    logic                 w_last;
    logic [SEL_WIDTH-1:0] w_ptr_eff;

    // The ack cycle already frees the frame, so the next frame's first word may land in it.
    assign w_ready     = !(r_pend && !bus.inAck);
    assign w_xfer      = bus.inValid && w_ready;
    assign w_seq_xfer  = w_xfer && bus.inMode;
    assign w_addr_xfer = w_xfer && !bus.inMode;
    assign w_sel_ok    = ({1'b0, bus.inSel} < (SEL_WIDTH+1)'(NUM_CHAN));
    assign w_ptr_eff   = (bus.inMode != r_mode_prev) ? '0 : r_ptr;
    assign w_last      = (w_ptr_eff == SEL_WIDTH'(NUM_CHAN-1));

    always_ff @(posedge inClk) begin
        if (inReset) begin
            r_data      <= '0;
            r_apulse    <= 1'b0;
            r_amask     <= '0;
            r_err       <= 1'b0;
            r_pend      <= 1'b0;
            r_ptr       <= '0;
            r_mode_prev <= 1'b0;
        end else begin
            r_mode_prev <= bus.inMode;
            r_apulse    <= 1'b0;
            r_amask     <= '0;
            r_err       <= 1'b0;

            if (w_seq_xfer) begin
                for (int k = 0; k < NUM_CHAN; k++)
                    if (w_ptr_eff == SEL_WIDTH'(k)) r_data[k] <= bus.inData;
                r_ptr <= w_last ? '0 : w_ptr_eff + SEL_WIDTH'(1);
            end else begin
                r_ptr <= w_ptr_eff;
            end

            // Completion wins over ack so a frame finished in the ack cycle stays flagged.
            if (w_seq_xfer && w_last)
                r_pend <= 1'b1;
            else if (bus.inAck)
                r_pend <= 1'b0;

            if (w_addr_xfer) begin
                if (w_sel_ok) begin
                    for (int k = 0; k < NUM_CHAN; k++)
                        if (bus.inSel == SEL_WIDTH'(k)) begin
                            r_data[k]  <= bus.inData;
                            r_amask[k] <= 1'b1;
                        end
                    r_apulse <= 1'b1;
                end else begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign bus.outReady    = w_ready;
    assign bus.outData     = r_data;
    assign bus.outValid    = r_pend || r_apulse;
    assign bus.outChanMask = r_pend ? {NUM_CHAN{1'b1}} : r_amask;
    assign bus.outError    = r_err;
endmodule

// File: tb/tb_demux_deser.sv
// Directed bench: a vector table on a 2-lane instance plus a hand-written
// invalid-lane sequence on a 3-lane instance.
module tb_demux_deser;
    logic clk = 1'b0;
    logic rst_a, rst_b;
    always #5 clk = ~clk;

    demux_deser_if #(.DATA_WIDTH(4), .NUM_CHAN(2), .SEL_WIDTH(1)) bus_a ();
    demux_deser_if #(.DATA_WIDTH(4), .NUM_CHAN(3), .SEL_WIDTH(2)) bus_b ();

    demux_deser #(.DATA_WIDTH(4), .NUM_CHAN(2), .SEL_WIDTH(1)) dut_a (
        .inClk(clk), .inReset(rst_a), .bus(bus_a));
    demux_deser #(.DATA_WIDTH(4), .NUM_CHAN(3), .SEL_WIDTH(2)) dut_b (
        .inClk(clk), .inReset(rst_b), .bus(bus_b));

    typedef struct {
        logic       rst, vld;
        logic [3:0] data;
        logic       sel, mode, ack;
        logic       chk_rdy, rdy;
        logic [7:0] odata;
        logic       ovld;
        logic [1:0] mask;
        logic       err;
    } vec_t;

    vec_t vq[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // rst vld data sel mode ack | chk_rdy rdy odata ovld mask err
    task automatic add(input logic rst, vld, input logic [3:0] d, input logic sel, mode, ack,
                       input logic ck, rdy, input logic [7:0] od, input logic ov,
                       input logic [1:0] m, input logic e);
        vec_t v;
        v.rst = rst; v.vld = vld; v.data = d; v.sel = sel; v.mode = mode; v.ack = ack;
        v.chk_rdy = ck; v.rdy = rdy; v.odata = od; v.ovld = ov; v.mask = m; v.err = e;
        vq.push_back(v);
    endtask

    task automatic apply_a(input int idx, input vec_t v);
        logic rdy_seen;
        @(negedge clk);
        rst_a = v.rst; bus_a.inValid = v.vld; bus_a.inData = v.data;
        bus_a.inSel = v.sel; bus_a.inMode = v.mode; bus_a.inAck = v.ack;
        #1 rdy_seen = bus_a.outReady;
        @(posedge clk);
        #1;
        n_vec++;
        if ((v.chk_rdy && rdy_seen !== v.rdy) || bus_a.outData !== v.odata ||
            bus_a.outValid !== v.ovld || bus_a.outChanMask !== v.mask || bus_a.outError !== v.err) begin
            n_bad++;
            $display("FAIL vec_a[%0d]: got rdy=%b data=%h vld=%b mask=%b err=%b, want rdy=%b data=%h vld=%b mask=%b err=%b",
                     idx, rdy_seen, bus_a.outData, bus_a.outValid, bus_a.outChanMask, bus_a.outError,
                     v.rdy, v.odata, v.ovld, v.mask, v.err);
        end
    endtask

    task automatic step_b(input string name, input logic rst, vld, input logic [3:0] d,
                          input logic [1:0] sel, input logic [11:0] od, input logic ov,
                          input logic [2:0] m, input logic e);
        @(negedge clk);
        rst_b = rst; bus_b.inValid = vld; bus_b.inData = d; bus_b.inSel = sel;
        @(posedge clk);
        #1;
        n_vec++;
        if (bus_b.outData !== od || bus_b.outValid !== ov || bus_b.outChanMask !== m || bus_b.outError !== e) begin
            n_bad++;
            $display("FAIL %s: got data=%h vld=%b mask=%b err=%b, want data=%h vld=%b mask=%b err=%b",
                     name, bus_b.outData, bus_b.outValid, bus_b.outChanMask, bus_b.outError, od, ov, m, e);
        end
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        bus_a.inValid = 0; bus_a.inData = 0; bus_a.inSel = 0; bus_a.inMode = 0; bus_a.inAck = 0;
        bus_b.inValid = 0; bus_b.inData = 0; bus_b.inSel = 0; bus_b.inMode = 0; bus_b.inAck = 0;

        add(1,0,4'h0,0,0,0, 0,1,8'h00,0,2'b00,0); // reset
        add(0,0,4'h0,0,0,0, 1,1,8'h00,0,2'b00,0);
        add(0,1,4'hA,1,0,0, 1,1,8'hA0,1,2'b10,0); // addressed lane 1
        add(0,1,4'h5,0,0,0, 1,1,8'hA5,1,2'b01,0); // addressed lane 0, back-to-back
        add(0,0,4'h0,0,0,0, 1,1,8'hA5,0,2'b00,0);
        add(0,1,4'h3,0,1,0, 1,1,8'hA3,0,2'b00,0); // seq, mode change -> lane 0
        add(0,1,4'hC,0,1,0, 1,1,8'hC3,1,2'b11,0); // frame complete
        add(0,1,4'h9,0,1,0, 1,0,8'hC3,1,2'b11,0); // stalled, word dropped
        add(0,0,4'h0,0,1,1, 1,1,8'hC3,0,2'b00,0); // ack
        add(0,1,4'h1,0,1,1, 1,1,8'hC1,0,2'b00,0); // full-throughput stream
        add(0,1,4'h2,0,1,1, 1,1,8'h21,1,2'b11,0);
        add(0,1,4'h3,0,1,1, 1,1,8'h23,0,2'b00,0);
        add(0,1,4'h4,0,1,1, 1,1,8'h43,1,2'b11,0);
        add(0,1,4'h5,0,1,1, 1,1,8'h45,0,2'b00,0);
        add(0,1,4'h6,0,1,1, 1,1,8'h65,1,2'b11,0);
        add(0,0,4'h0,0,1,1, 1,1,8'h65,0,2'b00,0);
        add(0,1,4'h7,0,1,0, 1,1,8'h67,0,2'b00,0); // partial frame
        add(0,0,4'h0,0,0,0, 1,1,8'h67,0,2'b00,0); // switch away discards it
        add(0,1,4'h1,0,1,0, 1,1,8'h61,0,2'b00,0); // back, restarts at lane 0
        add(0,1,4'h2,0,1,0, 1,1,8'h21,1,2'b11,0);
        add(0,0,4'h0,0,1,1, 1,1,8'h21,0,2'b00,0);
        add(0,1,4'h8,0,1,0, 1,1,8'h28,0,2'b00,0);
        add(0,1,4'h9,0,1,0, 1,1,8'h98,1,2'b11,0);
        add(0,1,4'hE,0,0,0, 1,0,8'h98,1,2'b11,0); // addressed write blocked by pending
        add(0,1,4'hE,0,0,1, 1,1,8'h9E,1,2'b01,0); // allowed in ack cycle
        add(0,1,4'h4,0,1,0, 1,1,8'h94,0,2'b00,0); // one word buffered
        add(1,1,4'h5,0,1,0, 0,1,8'h00,0,2'b00,0); // reset drops the word
        add(0,0,4'h0,0,1,0, 1,1,8'h00,0,2'b00,0);
        add(0,1,4'h1,0,1,0, 1,1,8'h01,0,2'b00,0);
        add(0,1,4'h2,0,1,0, 1,1,8'h21,1,2'b11,0);
        add(0,0,4'h0,0,1,1, 1,1,8'h21,0,2'b00,0);

        foreach (vq[i]) apply_a(i, vq[i]);

        step_b("b_reset",    1,0,4'h0,2'd0,12'h000,0,3'b000,0);
        step_b("b_lane2",    0,1,4'hB,2'd2,12'hB00,1,3'b100,0);
        step_b("b_bad_sel",  0,1,4'hF,2'd3,12'hB00,0,3'b000,1);
        step_b("b_err_drop", 0,0,4'h0,2'd0,12'hB00,0,3'b000,0);
        step_b("b_lane0",    0,1,4'h1,2'd0,12'hB01,1,3'b001,0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/demux_deser.md
Name: demux_deser

Overview:
- Parametrised, registered successor to the 1-to-2 nibble demultiplexer.
- Routes W-bit input words into one of NUM_CHAN lanes of a wide output register, using one of two modes:
  - addressed mode: the lane is chosen by inSel;
  - sequential mode: the lane is chosen by an auto-incrementing pointer, which deserialises NUM_CHAN words into one frame.
- Sits between the symbol/nibble datapath and byte/word consumers in the baseband chain.
- Replaces the tristate lane drivers with held registers and a valid/ack handshake.

Parameters:
- DATA_WIDTH, 4, bits per input word and per lane.
- NUM_CHAN, 2, number of output lanes; must be >= 2.
- SEL_WIDTH, 1, width of inSel and of the lane pointer; must satisfy 2**SEL_WIDTH >= NUM_CHAN.

Ports:
- inClk  input  1  rising-edge clock.
- inReset  input  1  synchronous reset, active high.
- inData  input  DATA_WIDTH  input word.
- inValid  input  1  inData is valid this cycle.
- outReady  output  1  block accepts a word this cycle. A transfer happens when inValid and outReady are both high.
- inSel  input  SEL_WIDTH  target lane in addressed mode; ignored in sequential mode.
- inMode  input  1  0 = addressed mode, 1 = sequential mode.
- inAck  input  1  downstream consumes a pending sequential frame.
- outData  output  NUM_CHAN*DATA_WIDTH  lane registers. Lane k occupies bits [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH].
- outValid  output  1  output update or frame is available.
- outChanMask  output  NUM_CHAN  lanes updated by the event flagged by outValid.
- outError  output  1  one-cycle pulse when an addressed write targets an invalid lane.

Behaviour:
- Reset (synchronous, takes effect on the next inClk edge): outData=0, outValid=0, outChanMask=0, outError=0, pointer=0, pending=0. outReady is therefore 1 after reset.
- outReady = not (pending and not inAck). This is a combinational path from inAck; there is no other combinational input-to-output path.
- Lanes not written in a cycle hold their value. Lanes are never driven to Z.

Addressed mode (inMode=0):
- On a transfer with inSel < NUM_CHAN:
  - lane inSel <= inData;
  - next cycle: outValid=1 for exactly one cycle, outChanMask = one-hot(inSel).
  - Latency is 1 cycle.
- On a transfer with inSel >= NUM_CHAN:
  - no lane is written;
  - next cycle: outError=1 for one cycle, outValid=0.
- Addressed pulses ignore inAck and never set pending.
- Back-to-back transfers on consecutive cycles give consecutive outValid pulses.

Sequential mode (inMode=1):
- On a transfer:
  - lane[pointer] <= inData;
  - if pointer = NUM_CHAN-1: pointer <= 0 and pending <= 1;
  - otherwise pointer <= pointer+1.
- Pending frame output:
  - from the cycle after the last word, outValid=1 and outChanMask = all ones;
  - both hold until a cycle with inAck=1;
  - pending clears at the end of that cycle.
- Ack on the completing edge: a transfer that completes a frame in the same cycle that acks the previous frame keeps pending=1 (the new frame is flagged). This gives full-throughput frames with no bubble when inAck is held high.
- inAck while pending=0 has no effect.
- Lane stability: lanes of a pending frame are stable until the ack cycle. The first word of the next frame is accepted only in the ack cycle or later, and that write lands in lane 0.

Mode change:
- inMode is sampled every cycle. A value differing from the previous cycle's value sets pointer <= 0 in that cycle.
- A partially filled sequential frame is discarded: no outValid, and its lanes keep the stale partial data.
- A transfer in the same cycle as the change uses the new mode, and in sequential mode it writes lane 0.
- A pending frame survives a switch to addressed mode. outReady stays low until inAck. Addressed writes are blocked meanwhile, so pending frame data is never overwritten.

Reset mid-frame:
- Clears pointer and pending and zeroes all lanes.
- A transfer presented in the reset cycle is dropped.

Test Plan:
- Reset, then addressed mode with DATA_WIDTH=4, NUM_CHAN=2:
  - inData=0xA, inSel=1 -> next cycle outData=0xA0, outValid=1, outChanMask=2'b10;
  - then inData=0x5, inSel=0 -> outData=0xA5, outChanMask=2'b01.
- Addressed mode, NUM_CHAN=3, SEL_WIDTH=2: inSel=3, inData=0xF -> outError=1 for one cycle, outValid=0, outData unchanged.
- Sequential mode, NUM_CHAN=2, inAck held 0: words 0x3 then 0xC ->
  - outValid=1, outData=0xC3, outChanMask=2'b11;
  - outReady=0, and a third word is not accepted while inAck=0;
  - inAck=1 -> outReady=1 that cycle, outValid=0 the next cycle.
- Sequential mode, inAck tied 1, inValid held 1 for 6 cycles with data 1,2,3,4,5,6 -> frames 0x21, 0x43, 0x65 flagged on consecutive frame boundaries, with no stall cycles.
- Sequential mode: word 0x7 accepted, then inMode switched to 0 -> pointer resets and no outValid. Back in sequential mode, words 0x1, 0x2 -> frame 0x21.
- Assert inReset with one word buffered in sequential mode -> next cycle outData=0, outValid=0, outReady=1. The next two words form a fresh frame starting at lane 0.
